// File: rtl/parking_gate_ctrl.sv
// Parking entry lane controller: PIN check with a limited number of tries,
// tailgate detection, grant timeout and a saturating lot occupancy counter.
module parking_gate_ctrl #(
  parameter int               PSW_W     = 8,
  parameter logic [PSW_W-1:0] PSWRD     = 8'h57,
  parameter int               MAX_TRIES = 3,
  parameter int               CAPACITY  = 16,
  parameter int               CNT_W     = 5,
  parameter int               GRANT_TO  = 32,
  parameter int               ATT_W     = ($clog2(MAX_TRIES+1) < 2) ? 2 : $clog2(MAX_TRIES+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor_1,
  input  logic             sensor_2,
  input  logic             sensor_exit,
  input  logic [PSW_W-1:0] psswrd_atmpt,
  input  logic             try_psswrd,
  output logic             alarm_1,
  output logic             alarm_2,
  output logic             open_gate,
  output logic             close_gate,
  output logic             parking_full,
  output logic [CNT_W-1:0] occupancy,
  output logic [ATT_W-1:0] attempts
);

  localparam int TMR_W = (GRANT_TO > 2) ? $clog2(GRANT_TO) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(GRANT_TO - 1);
  localparam logic [CNT_W-1:0] CAP       = CNT_W'(CAPACITY);
  localparam logic [ATT_W-1:0] ATT_LIMIT = ATT_W'(MAX_TRIES);

  typedef enum logic [2:0] {IDLE, PIN, GRANT, BLOCK, PIN_ALARM} state_t;

  typedef struct packed {
    logic attempt;
    logic correct;
    logic exit_ev;
  } evt_t;

  state_t           state, state_nxt;
  logic             try_q, exit_q;
  logic [TMR_W-1:0] timer;
  logic             att_inc, att_clr, passage;
  logic [ATT_W-1:0] att_plus;
  evt_t             ev;

  assign ev.attempt = try_psswrd & ~try_q;
  assign ev.correct = ev.attempt & (psswrd_atmpt == PSWRD);
  assign ev.exit_ev = sensor_exit & ~exit_q;
  assign att_plus   = attempts + ATT_W'(1);

  assign parking_full = (occupancy == CAP);

  always_comb begin
    state_nxt = state;
    att_inc   = 1'b0;
    att_clr   = 1'b0;
    passage   = 1'b0;
    case (state)
      IDLE: begin
        if (sensor_1 && sensor_2)           state_nxt = BLOCK;
        else if (sensor_1 && !parking_full) state_nxt = PIN;
      end
      PIN: begin
        if (sensor_2) state_nxt = BLOCK;
        else if (ev.attempt) begin
          if (ev.correct) begin
            state_nxt = GRANT;
            att_clr   = 1'b1;
          end else begin
            att_inc = 1'b1;
            if (att_plus == ATT_LIMIT) state_nxt = PIN_ALARM;
          end
        end else if (!sensor_1) state_nxt = IDLE;
      end
      GRANT: begin
        if (sensor_1 && sensor_2) state_nxt = BLOCK;
        else if (sensor_2) begin
          state_nxt = IDLE;
          passage   = 1'b1;
        end else if (timer == TMR_LAST) state_nxt = IDLE;
      end
      BLOCK: begin
        if (ev.correct) state_nxt = IDLE;
      end
      PIN_ALARM: begin
        // Keypad stays live while latched; counter saturates rather than wrapping.
        if (ev.attempt && !ev.correct && attempts != '1) att_inc = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      try_q      <= 1'b0;
      exit_q     <= 1'b0;
      timer      <= '0;
      attempts   <= '0;
      occupancy  <= '0;
      open_gate  <= 1'b0;
      close_gate <= 1'b1;
      alarm_1    <= 1'b0;
      alarm_2    <= 1'b0;
    end else begin
      state      <= state_nxt;
      try_q      <= try_psswrd;
      exit_q     <= sensor_exit;
      open_gate  <= (state_nxt == GRANT);
      close_gate <= (state_nxt != GRANT);
      alarm_1    <= (state_nxt == PIN_ALARM);
      alarm_2    <= (state_nxt == BLOCK);
      // Timer restarts from 0 on every fresh entry into GRANT.
      timer      <= (state == GRANT && state_nxt == GRANT) ? timer + TMR_W'(1) : '0;
      if (att_clr)      attempts <= '0;
      else if (att_inc) attempts <= att_plus;
      case ({passage, ev.exit_ev})
        2'b10:   if (occupancy < CAP)  occupancy <= occupancy + CNT_W'(1);
        2'b01:   if (occupancy != '0)  occupancy <= occupancy - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl with small CAPACITY/GRANT_TO so the
// full-lot and timeout paths are short.
module tb_parking_gate_ctrl;
  localparam int CAP  = 4;
  localparam int GTO  = 6;
  localparam logic [7:0] GOOD = 8'h57;
  localparam logic [7:0] BAD  = 8'h5F;

  logic       clk = 1'b0;
  logic       rst, sensor_1, sensor_2, sensor_exit, try_psswrd;
  logic [7:0] psswrd_atmpt;
  logic       alarm_1, alarm_2, open_gate, close_gate, parking_full;
  logic [4:0] occupancy;
  logic [1:0] attempts;

  int n_cmp = 0;
  int n_err = 0;

  parking_gate_ctrl #(.PSW_W(8), .PSWRD(8'h57), .MAX_TRIES(3), .CAPACITY(CAP),
                      .CNT_W(5), .GRANT_TO(GTO)) dut (
    .clk(clk), .rst(rst), .sensor_1(sensor_1), .sensor_2(sensor_2),
    .sensor_exit(sensor_exit), .psswrd_atmpt(psswrd_atmpt), .try_psswrd(try_psswrd),
    .alarm_1(alarm_1), .alarm_2(alarm_2), .open_gate(open_gate), .close_gate(close_gate),
    .parking_full(parking_full), .occupancy(occupancy), .attempts(attempts)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_try(input logic [7:0] code);
    psswrd_atmpt = code;
    try_psswrd   = 1'b1;
    tick();
  endtask

  // car arrives, enters the correct PIN, drives through
  task automatic enter_car();
    sensor_1 = 1'b1; tick();
    pulse_try(GOOD);
    chk("entry_open", open_gate, 1'b1);
    try_psswrd = 1'b0; sensor_1 = 1'b0; tick();
    sensor_2 = 1'b1; tick();
    sensor_2 = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; sensor_1 = 0; sensor_2 = 0; sensor_exit = 0; try_psswrd = 0; psswrd_atmpt = '0;
    tick(); tick();
    chk("rst_open", open_gate, 0);
    chk("rst_close", close_gate, 1);
    chk("rst_alarm1", alarm_1, 0);
    chk("rst_alarm2", alarm_2, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_att", attempts, 0);
    chk("rst_full", parking_full, 0);
    rst = 1'b0; tick();

    // normal entry
    enter_car();
    chk("norm_open", open_gate, 0);
    chk("norm_close", close_gate, 1);
    chk("norm_occ", occupancy, 1);
    chk("norm_att", attempts, 0);

    // two wrong (one held for 5 cycles), then correct
    sensor_1 = 1'b1; tick();
    pulse_try(BAD);
    chk("w1_att", attempts, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("hold_att", attempts, 1);
    try_psswrd = 1'b0; tick();
    pulse_try(BAD);
    chk("w2_att", attempts, 2);
    chk("w2_alarm1", alarm_1, 0);
    try_psswrd = 1'b0; tick();
    pulse_try(GOOD);
    chk("w2_ok_open", open_gate, 1);
    chk("w2_ok_att", attempts, 0);
    chk("w2_ok_alarm1", alarm_1, 0);
    try_psswrd = 1'b0; sensor_1 = 1'b0; tick();
    sensor_2 = 1'b1; tick();
    sensor_2 = 1'b0; tick();
    chk("w2_occ", occupancy, 2);

    // three wrong -> latched PIN alarm
    sensor_1 = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      pulse_try(BAD);
      try_psswrd = 1'b0; tick();
    end
    chk("w3_alarm1", alarm_1, 1);
    chk("w3_att", attempts, 3);
    chk("w3_open", open_gate, 0);
    pulse_try(GOOD);
    try_psswrd = 1'b0; tick();
    chk("w3_good_alarm1", alarm_1, 1);
    chk("w3_good_open", open_gate, 0);
    chk("w3_good_att", attempts, 3);
    sensor_exit = 1'b1; tick();
    chk("w3_exit_occ", occupancy, 1);
    sensor_exit = 1'b0; sensor_1 = 1'b0;
    rst = 1'b1; tick();
    chk("w3_rst_alarm1", alarm_1, 0);
    chk("w3_rst_att", attempts, 0);
    chk("w3_rst_occ", occupancy, 0);
    rst = 1'b0; tick();

    // tailgate
    sensor_1 = 1'b1; sensor_2 = 1'b1; tick();
    chk("tg_alarm2", alarm_2, 1);
    sensor_1 = 1'b0; sensor_2 = 1'b0;
    pulse_try(BAD);
    chk("tg_bad_alarm2", alarm_2, 1);
    chk("tg_bad_att", attempts, 0);
    try_psswrd = 1'b0; tick();
    pulse_try(GOOD);
    chk("tg_good_alarm2", alarm_2, 0);
    chk("tg_good_open", open_gate, 0);
    try_psswrd = 1'b0; tick();

    // fill the lot
    for (int i = 0; i < CAP; i++) enter_car();
    chk("full_occ", occupancy, CAP);
    chk("full_flag", parking_full, 1);
    sensor_1 = 1'b1; tick();
    pulse_try(GOOD);
    chk("full_refuse", open_gate, 0);
    try_psswrd = 1'b0; sensor_1 = 1'b0; tick();
    sensor_exit = 1'b1; tick();
    chk("exit_occ", occupancy, CAP - 1);
    chk("exit_full", parking_full, 0);
    sensor_exit = 1'b0; tick();
    sensor_1 = 1'b1; tick();
    pulse_try(GOOD);
    chk("reentry_open", open_gate, 1);
    try_psswrd = 1'b0; sensor_1 = 1'b0; tick();
    sensor_2 = 1'b1; sensor_exit = 1'b1; tick();
    chk("both_occ", occupancy, CAP - 1);
    chk("both_open", open_gate, 0);
    sensor_2 = 1'b0; sensor_exit = 1'b0; tick();

    // grant timeout
    sensor_1 = 1'b1; tick();
    pulse_try(GOOD);
    chk("to_open0", open_gate, 1);
    try_psswrd = 1'b0; sensor_1 = 1'b0;
    for (int i = 0; i < GTO - 1; i++) tick();
    chk("to_open_last", open_gate, 1);
    tick();
    chk("to_closed", open_gate, 0);
    chk("to_occ", occupancy, CAP - 1);

    // reset mid-grant
    sensor_1 = 1'b1; tick();
    pulse_try(GOOD);
    try_psswrd = 1'b0; sensor_1 = 1'b0; tick();
    chk("mid_open", open_gate, 1);
    rst = 1'b1; tick();
    chk("mid_rst_open", open_gate, 0);
    chk("mid_rst_close", close_gate, 1);
    chk("mid_rst_occ", occupancy, 0);
    rst = 1'b0; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
